nes_int_ctrl: RTL and testbench

- Interrupt/reset sequencer for the 6502 core. It is the producer side of the instruction controller's `int_flag` handshake.
- Detects NMI edges, IRQ levels and the post-reset request, and arbitrates them.
- Raises `int_flag` so that the next T1 latches BRK (0x00) instead of the fetched opcode.
- Tells the BRK microcode which vector to fetch, whether to push B=0, and whether to suppress bus writes.

---
 rtl/nes_int_ctrl_if.sv | 43 ++++
 rtl/nes_int_ctrl.sv | 178 +++++++++++++++++
 tb/tb_nes_int_ctrl.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nes_int_ctrl_if.sv
// -----------------------------------------------------------------------------
// nes_int_ctrl_if
// Groups the pin-side inputs, the instruction-controller handshake and the
// BRK-microcode steering outputs of the 6502 interrupt/reset sequencer.
//
// Signals:
//   nmi_n       NMI pin, active-low, edge-sensitive
//   irq_n       IRQ pin, active-low, level-sensitive
//   i_flag      processor status I bit (1 = IRQ masked)
//   t1_next     closing edge of this cycle loads a new opcode
//   vec_fetch   BRK sequence reads the vector low byte this cycle
//   int_flag    request BRK injection at the next T1
//   vector_sel  00 = IRQ/BRK, 01 = NMI, 10 = RESET
//   hw_int      current BRK is hardware-injected (push B=0, hold PC)
//   rw_suppress reset sequence active, stack pushes become reads
//   nmi_pending latched NMI edge not yet serviced (debug)
//
// Modports:
//   slave  - the sequencer itself
//   master - the CPU core / pins side that drives the inputs
// -----------------------------------------------------------------------------
interface nes_int_ctrl_if;
  logic       nmi_n;
  logic       irq_n;
  logic       i_flag;
  logic       t1_next;
  logic       vec_fetch;
  logic       int_flag;
  logic [1:0] vector_sel;
  logic       hw_int;
  logic       rw_suppress;
  logic       nmi_pending;

  modport slave (
    input  nmi_n, irq_n, i_flag, t1_next, vec_fetch,
    output int_flag, vector_sel, hw_int, rw_suppress, nmi_pending
  );

  modport master (
    output nmi_n, irq_n, i_flag, t1_next, vec_fetch,
    input  int_flag, vector_sel, hw_int, rw_suppress, nmi_pending
  );
endinterface

// File: rtl/nes_int_ctrl.sv
// -----------------------------------------------------------------------------
// nes_int_ctrl
// Interrupt/reset sequencer for the 6502 core. Synchronises the NMI/IRQ pins,
// latches NMI falling edges, arbitrates NMI > IRQ, and raises int_flag so the
// instruction controller substitutes BRK at the next T1. While the injected
// BRK runs it steers the vector fetch, the B flag and write suppression.
//
// Ports:
//   clk_ph1  CPU phase-1 clock, all state changes on its rising edge
//   rst      asynchronous active-high reset (re-enters the RESET sequence)
//   bus      nes_int_ctrl_if.slave (pins, T1 handshake, vector steering)
//
// Parameters:
//   NMI_SYNC_STAGES  flops on nmi_n / irq_n before detection (1..3)
//
// Optional build macro:
//   NES_NMI_HIJACK_EN  an NMI that becomes pending while an IRQ BRK is still
//                      before its vector fetch redirects that BRK to the NMI
//                      vector (6502 vector hijacking). Undefined: source and
//                      vector are frozen for the whole service.
// -----------------------------------------------------------------------------
module nes_int_ctrl #(
  parameter int NMI_SYNC_STAGES = 2
) (
  input  logic          clk_ph1,
  input  logic          rst,
  nes_int_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Encoded so that the source doubles as the vector select value.
  typedef enum logic [1:0] {
    SRC_IRQ   = 2'b00,
    SRC_NMI   = 2'b01,
    SRC_RESET = 2'b10
  } src_t;

  state_t state, state_nx;
  src_t   src, src_nx;

  logic       int_flag_q, int_flag_nx;
  logic       hw_int_q, hw_int_nx;
  logic       rw_suppress_q, rw_suppress_nx;
  logic [1:0] vector_sel_q, vector_sel_nx;
  logic       nmi_pending_q, nmi_pending_nx;

  logic [NMI_SYNC_STAGES-1:0] nmi_sync;
  logic [NMI_SYNC_STAGES-1:0] irq_sync;
  logic                       nmi_prev;

  logic nmi_s;
  logic irq_s;
  logic nmi_edge;
  logic irq_req;
  logic pend_clr;

  // ---------------------------------------------------------------------------
  // Pin synchronisers. Reset to the inactive level so that no false NMI edge
  // or IRQ request appears straight out of reset.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values; blocking here would collapse the chain.
  always_ff @(posedge clk_ph1 or posedge rst) begin
    if (rst) begin
      nmi_sync <= '1;
      irq_sync <= '1;
      nmi_prev <= 1'b1;
    end else begin
      nmi_sync[0] <= bus.nmi_n;
      irq_sync[0] <= bus.irq_n;
      for (int i = 1; i < NMI_SYNC_STAGES; i++) begin
        nmi_sync[i] <= nmi_sync[i-1];
        irq_sync[i] <= irq_sync[i-1];
      end
      nmi_prev <= nmi_s;
    end
  end

  assign nmi_s    = nmi_sync[NMI_SYNC_STAGES-1];
  assign irq_s    = irq_sync[NMI_SYNC_STAGES-1];
  // Only the high-to-low transition counts, so a held-low NMI fires once.
  assign nmi_edge = nmi_prev & ~nmi_s;
  assign irq_req  = ~irq_s & ~bus.i_flag;

  // ---------------------------------------------------------------------------
  // State and output registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_ph1 or posedge rst) begin
    if (rst) begin
      state         <= ARMED;
      src           <= SRC_RESET;
      int_flag_q    <= 1'b1;
      hw_int_q      <= 1'b1;
      rw_suppress_q <= 1'b1;
      vector_sel_q  <= 2'b10;
      nmi_pending_q <= 1'b0;
    end else begin
      state         <= state_nx;
      src           <= src_nx;
      int_flag_q    <= int_flag_nx;
      hw_int_q      <= hw_int_nx;
      rw_suppress_q <= rw_suppress_nx;
      vector_sel_q  <= vector_sel_nx;
      nmi_pending_q <= nmi_pending_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic.
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets its hold value first so no path through the case
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx       = state;
    src_nx         = src;
    int_flag_nx    = int_flag_q;
    hw_int_nx      = hw_int_q;
    rw_suppress_nx = rw_suppress_q;
    vector_sel_nx  = vector_sel_q;
    pend_clr       = 1'b0;

    unique case (state)
      IDLE: begin
        // vec_fetch from a software BRK is ignored here; vector_sel rests 00.
        if (nmi_pending_q || irq_req) begin
          state_nx      = ARMED;
          src_nx        = nmi_pending_q ? SRC_NMI : SRC_IRQ;
          vector_sel_nx = src_nx;
          int_flag_nx   = 1'b1;
          hw_int_nx     = 1'b1;
        end
      end

      ARMED: begin
        // A T1 in the arming cycle itself is not seen: we were still IDLE.
        if (bus.t1_next) begin
          state_nx    = SERVICE;
          int_flag_nx = 1'b0;
        end
      end

      SERVICE: begin
        if (bus.vec_fetch) begin
          state_nx       = IDLE;
          hw_int_nx      = 1'b0;
          rw_suppress_nx = 1'b0;
          vector_sel_nx  = 2'b00;
          pend_clr       = (src == SRC_NMI);
        end
`ifdef NES_NMI_HIJACK_EN
        else if (src == SRC_IRQ && nmi_pending_q) begin
          src_nx        = SRC_NMI;
          vector_sel_nx = SRC_NMI;
        end
`endif
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    // A fresh edge on the clearing edge must survive: set wins over clear.
    nmi_pending_nx = nmi_edge | (nmi_pending_q & ~pend_clr);
  end

  assign bus.int_flag    = int_flag_q;
  assign bus.hw_int      = hw_int_q;
  assign bus.rw_suppress = rw_suppress_q;
  assign bus.vector_sel  = vector_sel_q;
  assign bus.nmi_pending = nmi_pending_q;

endmodule

// File: tb/tb_nes_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nes_int_ctrl
// Directed scenarios with fixed expectations, followed by a randomized run
// compared every cycle against a behavioural model of the sequencer.
// Observed vector layout: {int_flag, vector_sel[1:0], hw_int, rw_suppress,
// nmi_pending}.
// -----------------------------------------------------------------------------
module tb_nes_int_ctrl;

  localparam int STAGES = 2;

  logic clk_ph1;
  logic rst;

  nes_int_ctrl_if ifc ();

  nes_int_ctrl #(.NMI_SYNC_STAGES(STAGES)) dut (
    .clk_ph1 (clk_ph1),
    .rst     (rst),
    .bus     (ifc)
  );

  initial begin
    clk_ph1 = 1'b0;
    forever #5 clk_ph1 = ~clk_ph1;
  end

  int total = 0;
  int bad   = 0;

  // ---------------------------------------------------------------------------
  // Behavioural model: pin history queues, a pending flag, and two booleans
  // describing whether a request waits for T1 or a BRK is between T1 and its
  // vector fetch. Outputs are derived from those facts.
  // ---------------------------------------------------------------------------
  bit nq[$];
  bit iq[$];
  bit m_prev;
  bit m_wait;
  bit m_seq;
  bit m_pend;
  int m_src;   // 0 = IRQ, 1 = NMI, 2 = RESET

  function automatic void model_reset();
    nq.delete();
    iq.delete();
    for (int i = 0; i < STAGES; i++) begin
      nq.push_back(1'b1);
      iq.push_back(1'b1);
    end
    m_prev = 1'b1;
    m_wait = 1'b1;
    m_seq  = 1'b0;
    m_pend = 1'b0;
    m_src  = 2;
  endfunction

  function automatic void model_edge(bit s_rst, bit s_nmi, bit s_irq, bit s_i,
                                     bit s_t1, bit s_vec);
    bit nmi_now;
    bit fell;
    bit want_irq;
    bit clr;
    if (s_rst) begin
      model_reset();
      return;
    end
    nmi_now  = nq[0];
    fell     = m_prev && !nmi_now;
    want_irq = !iq[0] && !s_i;
    clr      = 1'b0;
    if (m_seq) begin
      if (s_vec) begin
        clr   = (m_src == 1);
        m_seq = 1'b0;
      end
`ifdef NES_NMI_HIJACK_EN
      else if (m_src == 0 && m_pend) begin
        m_src = 1;
      end
`endif
    end else if (m_wait) begin
      if (s_t1) begin
        m_wait = 1'b0;
        m_seq  = 1'b1;
      end
    end else if (m_pend || want_irq) begin
      m_wait = 1'b1;
      m_src  = m_pend ? 1 : 0;
    end
    if (fell) m_pend = 1'b1;
    else if (clr) m_pend = 1'b0;
    m_prev = nmi_now;
    nq.push_back(s_nmi);
    void'(nq.pop_front());
    iq.push_back(s_irq);
    void'(iq.pop_front());
  endfunction

  function automatic logic [5:0] model_snap();
    bit         active;
    logic [1:0] v;
    active = m_wait || m_seq;
    v      = active ? 2'(m_src) : 2'b00;
    return {m_wait, v, active, (active && m_src == 2), m_pend};
  endfunction

  function automatic logic [5:0] snap();
    return {ifc.int_flag, ifc.vector_sel, ifc.hw_int, ifc.rw_suppress,
            ifc.nmi_pending};
  endfunction

  // Advance one clock: sample inputs, step the model on the edge, settle.
  task automatic tick();
    bit s_rst, s_nmi, s_irq, s_i, s_t1, s_vec;
    s_rst = rst;
    s_nmi = ifc.nmi_n;
    s_irq = ifc.irq_n;
    s_i   = ifc.i_flag;
    s_t1  = ifc.t1_next;
    s_vec = ifc.vec_fetch;
    @(posedge clk_ph1);
    model_edge(s_rst, s_nmi, s_irq, s_i, s_t1, s_vec);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [5:0] want;
    rst = 1'b1;
    tick();
    tick();
    want = 6'b1_10_1_1_0;
    total++;
    if (snap() !== want) begin
      bad++; $display("FAIL reset_state got=%b want=%b", snap(), want);
    end
    rst = 1'b0;
    tick();
    total++;
    if (snap() !== want) begin
      bad++; $display("FAIL reset_armed_hold got=%b want=%b", snap(), want);
    end
    ifc.vec_fetch = 1'b1;
    tick();
    ifc.vec_fetch = 1'b0;
    total++;
    if (snap() !== want) begin
      bad++; $display("FAIL vec_ignored_armed got=%b want=%b", snap(), want);
    end
    ifc.t1_next = 1'b1;
    tick();
    ifc.t1_next = 1'b0;
    want = 6'b0_10_1_1_0;
    total++;
    if (snap() !== want) begin
      bad++; $display("FAIL reset_after_t1 got=%b want=%b", snap(), want);
    end
    tick();
    tick();
    total++;
    if (snap() !== want) begin
      bad++; $display("FAIL reset_service_wait got=%b want=%b", snap(), want);
    end
    ifc.vec_fetch = 1'b1;
    tick();
    ifc.vec_fetch = 1'b0;
    want = 6'b0_00_0_0_0;
    total++;
    if (snap() !== want) begin
      bad++; $display("FAIL reset_after_vec got=%b want=%b", snap(), want);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_irq();
    logic [5:0] want;
    ifc.i_flag  = 1'b0;
    ifc.irq_n   = 1'b0;
    ifc.t1_next = 1'b1;   // held high: the arming-edge T1 must be ignored
    for (int e = 1; e <= STAGES; e++) begin
      tick();
      want = 6'b0_00_0_0_0;
      total++;
      if (snap() !== want) begin
        bad++; $display("FAIL irq_latency_edge%0d got=%b want=%b", e, snap(), want);
      end
    end
    tick();
    want = 6'b1_00_1_0_0;
    total++;
    if (snap() !== want) begin
      bad++; $display("FAIL irq_arm got=%b want=%b", snap(), want);
    end
    tick();
    ifc.t1_next = 1'b0;
    ifc.i_flag  = 1'b1;
    ifc.irq_n   = 1'b1;
    want = 6'b0_00_1_0_0;
    total++;
    if (snap() !== want) begin
      bad++; $display("FAIL irq_after_t1 got=%b want=%b", snap(), want);
    end
    tick();
    total++;
    if (snap() !== want) begin
      bad++; $display("FAIL irq_not_cancelled got=%b want=%b", snap(), want);
    end
    ifc.vec_fetch = 1'b1;
    tick();
    ifc.vec_fetch = 1'b0;
    want = 6'b0_00_0_0_0;
    total++;
    if (snap() !== want) begin
      bad++; $display("FAIL irq_after_vec got=%b want=%b", snap(), want);
    end
    ifc.irq_n = 1'b0;     // masked by i_flag
    for (int c = 0; c < 20; c++) begin
      tick();
      total++;
      if (snap() !== want) begin
        bad++; $display("FAIL irq_masked_cycle%0d got=%b want=%b", c, snap(), want);
      end
    end
    ifc.irq_n = 1'b1;
    repeat (STAGES + 1) tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_nmi_held();
    logic [5:0] want;
    ifc.nmi_n = 1'b0;
    repeat (STAGES) tick();
    tick();
    want = 6'b0_00_0_0_1;
    total++;
    if (snap() !== want) begin
      bad++; $display("FAIL nmi_pending_set got=%b want=%b", snap(), want);
    end
    tick();
    want = 6'b1_01_1_0_1;
    total++;
    if (snap() !== want) begin
      bad++; $display("FAIL nmi_arm got=%b want=%b", snap(), want);
    end
    ifc.t1_next = 1'b1;
    tick();
    ifc.t1_next = 1'b0;
    want = 6'b0_01_1_0_1;
    total++;
    if (snap() !== want) begin
      bad++; $display("FAIL nmi_after_t1 got=%b want=%b", snap(), want);
    end
    ifc.vec_fetch = 1'b1;
    tick();
    ifc.vec_fetch = 1'b0;
    want = 6'b0_00_0_0_0;
    total++;
    if (snap() !== want) begin
      bad++; $display("FAIL nmi_after_vec got=%b want=%b", snap(), want);
    end
    for (int c = 0; c < 44; c++) begin
      tick();
      total++;
      if (snap() !== want) begin
        bad++; $display("FAIL nmi_held_once_cycle%0d got=%b want=%b", c, snap(), want);
      end
    end
    ifc.nmi_n = 1'b1;
    repeat (STAGES + 1) tick();
    total++;
    if (snap() !== want) begin
      bad++; $display("FAIL nmi_rise_quiet got=%b want=%b", snap(), want);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_priority();
    logic [5:0] want;
    ifc.nmi_n  = 1'b0;
    ifc.i_flag = 1'b0;
    tick();
    ifc.irq_n = 1'b0;     // NMI edge and IRQ request become visible together
    repeat (STAGES) tick();
    want = 6'b0_00_0_0_1;
    total++;
    if (snap() !== want) begin
      bad++; $display("FAIL prio_both_seen got=%b want=%b", snap(), want);
    end
    tick();
    want = 6'b1_01_1_0_1;
    total++;
    if (snap() !== want) begin
      bad++; $display("FAIL prio_first_nmi got=%b want=%b", snap(), want);
    end
    ifc.t1_next = 1'b1;
    tick();
    ifc.t1_next   = 1'b0;
    ifc.vec_fetch = 1'b1;
    tick();
    ifc.vec_fetch = 1'b0;
    tick();
    want = 6'b1_00_1_0_0;
    total++;
    if (snap() !== want) begin
      bad++; $display("FAIL prio_second_irq got=%b want=%b", snap(), want);
    end
    ifc.i_flag  = 1'b1;
    ifc.irq_n   = 1'b1;
    ifc.t1_next = 1'b1;
    tick();
    ifc.t1_next   = 1'b0;
    ifc.vec_fetch = 1'b1;
    tick();
    ifc.vec_fetch = 1'b0;
    ifc.nmi_n     = 1'b1;
    repeat (STAGES + 2) tick();
    want = 6'b0_00_0_0_0;
    total++;
    if (snap() !== want) begin
      bad++; $display("FAIL prio_settled got=%b want=%b", snap(), want);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_nmi_during_irq();
    logic [5:0] want;
    ifc.i_flag = 1'b0;
    ifc.irq_n  = 1'b0;
    repeat (STAGES + 1) tick();
    ifc.t1_next = 1'b1;
    tick();
    ifc.t1_next = 1'b0;
    ifc.irq_n   = 1'b1;
    ifc.i_flag  = 1'b1;
    ifc.nmi_n   = 1'b0;
    want = 6'b0_00_1_0_0;
    total++;
    if (snap() !== want) begin
      bad++; $display("FAIL hij_irq_service got=%b want=%b", snap(), want);
    end
    repeat (STAGES) tick();
    tick();
    want = 6'b0_00_1_0_1;
    total++;
    if (snap() !== want) begin
      bad++; $display("FAIL hij_pending got=%b want=%b", snap(), want);
    end
    tick();
`ifdef NES_NMI_HIJACK_EN
    want = 6'b0_01_1_0_1;
`else
    want = 6'b0_00_1_0_1;
`endif
    total++;
    if (snap() !== want) begin
      bad++; $display("FAIL hij_vsel_at_vec got=%b want=%b", snap(), want);
    end
    ifc.vec_fetch = 1'b1;
    tick();
    ifc.vec_fetch = 1'b0;
`ifdef NES_NMI_HIJACK_EN
    want = 6'b0_00_0_0_0;
`else
    want = 6'b0_00_0_0_1;
`endif
    total++;
    if (snap() !== want) begin
      bad++; $display("FAIL hij_after_vec got=%b want=%b", snap(), want);
    end
    tick();
`ifdef NES_NMI_HIJACK_EN
    want = 6'b0_00_0_0_0;
`else
    want = 6'b1_01_1_0_1;
`endif
    total++;
    if (snap() !== want) begin
      bad++; $display("FAIL hij_followup got=%b want=%b", snap(), want);
    end
`ifndef NES_NMI_HIJACK_EN
    ifc.t1_next = 1'b1;
    tick();
    ifc.t1_next   = 1'b0;
    ifc.vec_fetch = 1'b1;
    tick();
    ifc.vec_fetch = 1'b0;
    want = 6'b0_00_0_0_0;
    total++;
    if (snap() !== want) begin
      bad++; $display("FAIL hij_second_done got=%b want=%b", snap(), want);
    end
`endif
    ifc.nmi_n = 1'b1;
    repeat (STAGES + 2) tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_service();
    logic [5:0] want;
    ifc.nmi_n = 1'b0;
    repeat (STAGES + 2) tick();
    ifc.t1_next = 1'b1;
    tick();
    ifc.t1_next = 1'b0;
    ifc.nmi_n   = 1'b1;
    want = 6'b0_01_1_0_1;
    total++;
    if (snap() !== want) begin
      bad++; $display("FAIL rst_pre_service got=%b want=%b", snap(), want);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    want = 6'b1_10_1_1_0;
    total++;
    if (snap() !== want) begin
      bad++; $display("FAIL rst_mid_service got=%b want=%b", snap(), want);
    end
    tick();
    rst = 1'b0;
    ifc.t1_next = 1'b1;
    tick();
    ifc.t1_next   = 1'b0;
    ifc.vec_fetch = 1'b1;
    tick();
    ifc.vec_fetch = 1'b0;
    want = 6'b0_00_0_0_0;
    total++;
    if (snap() !== want) begin
      bad++; $display("FAIL rst_seq_done got=%b want=%b", snap(), want);
    end
    repeat (STAGES + 2) tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(15) == 0) ifc.nmi_n  = ~ifc.nmi_n;
      if ($urandom_range(7) == 0)  ifc.irq_n  = ~ifc.irq_n;
      if ($urandom_range(7) == 0)  ifc.i_flag = ~ifc.i_flag;
      ifc.t1_next   = ($urandom_range(3) == 0);
      ifc.vec_fetch = ($urandom_range(3) == 0);
      rst           = ($urandom_range(199) == 0);
      tick();
      total++;
      if (snap() !== model_snap()) begin
        bad++;
        $display("FAIL random_cycle%0d got=%b want=%b", c, snap(), model_snap());
      end
    end
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst           = 1'b1;
    ifc.nmi_n     = 1'b1;
    ifc.irq_n     = 1'b1;
    ifc.i_flag    = 1'b1;
    ifc.t1_next   = 1'b0;
    ifc.vec_fetch = 1'b0;
    model_reset();
    test_reset();
    test_irq();
    test_nmi_held();
    test_priority();
    test_nmi_during_irq();
    test_reset_mid_service();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
